sig_sweep_ctrl: RTL and testbench
=================================

SIG_SWEEP_CTRL -- requirements
Module: sig_sweep_ctrl

Interface
REQ-001 SHALL have parameter PHASE_W, default 16, width of frequency/phase-increment words.
REQ-002 SHALL have parameter DWELL_W, default 16, width of dwell counter.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port abort  input  1  one-cycle request to terminate the sweep.
REQ-007 SHALL have port cfg_f_start  input  PHASE_W  first phase increment.
REQ-008 SHALL have port cfg_f_stop  input  PHASE_W  upper limit of phase increment (inclusive).
REQ-009 SHALL have port cfg_f_step  input  PHASE_W  increment added per step.
REQ-010 SHALL have port cfg_dwell  input  DWELL_W  each tone is held cfg_dwell+1 cycles.
REQ-011 SHALL have port cfg_repeat  input  1  1 = restart at cfg_f_start after last tone.
REQ-012 SHALL have port phase_inc  output  PHASE_W  registered increment to the signal generator.
REQ-013 SHALL have port tone_en  output  1  registered; generator output valid/enabled.
REQ-014 SHALL have port busy  output  1  registered; high in any state other than IDLE.
REQ-015 SHALL have port sweep_done  output  1  registered one-cycle pulse at normal sweep completion.

Function
REQ-016 SHALL implement states IDLE and DWELL; busy = (state == DWELL).
REQ-017 SHALL, in IDLE with start=1 and abort=0, copy all cfg_* inputs into shadow registers, load phase_inc=cfg_f_start, dwell counter=cfg_dwell, set tone_en=1, enter DWELL on the same edge.
REQ-018 SHALL ignore cfg_* changes while busy; only shadow values are used.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL, in DWELL with counter != 0, decrement counter by 1 per cycle, phase_inc unchanged.
REQ-021 SHALL, in DWELL with counter == 0, compute next = phase_inc + f_step in PHASE_W+1 bits (no wrap).
REQ-022 SHALL, if f_step != 0 and next <= f_stop, load phase_inc=next[PHASE_W-1:0], reload counter=dwell, stay in DWELL.
REQ-023 SHALL otherwise treat the tone as last: if repeat=1, load phase_inc=f_start, reload counter, stay in DWELL, no sweep_done.
REQ-024 SHALL, on last tone with repeat=0, enter IDLE, clear tone_en, assert sweep_done for exactly one cycle, and hold phase_inc at the last tone value.
REQ-025 SHALL treat f_step=0 or f_start > f_stop as a single tone of f_start lasting dwell+1 cycles.
REQ-026 SHALL, on abort=1 in any state, enter IDLE on the next edge, clear tone_en, not pulse sweep_done; abort wins over simultaneous start or completion.
REQ-027 SHALL have latency: start sampled at edge N -> phase_inc/tone_en/busy updated after edge N; sweep_done and tone_en fall coincide.

Reset
REQ-028 SHALL, while resetn=0 at a rising edge, force state=IDLE, phase_inc=0, tone_en=0, busy=0, sweep_done=0, counter=0, shadow registers=0.
REQ-029 SHALL take reset priority over start and abort; reset mid-sweep aborts without sweep_done.

Verification
REQ-030 SHALL cover basic sweep: f_start=0x1000, f_stop=0x1300, f_step=0x100, dwell=3, repeat=0 -> phase_inc 0x1000,0x1100,0x1200,0x1300 each 4 cycles, sweep_done single pulse after 16 busy cycles, tone_en low.
REQ-031 SHALL cover overflow guard: f_start=0xFF00, f_stop=0xFFFF, f_step=0x80, dwell=0 -> tones 0xFF00, 0xFF80 only, no wrap to 0x0000, then done.
REQ-032 SHALL cover repeat: REQ-030 settings with repeat=1 -> after 0x1300 returns to 0x1000 with no sweep_done; abort mid-tone -> busy=0, tone_en=0 next cycle, no sweep_done.
REQ-033 SHALL cover degenerate configs: f_step=0 or f_start=0x2000 > f_stop=0x1000, dwell=5 -> single tone 0x2000 for 6 cycles, then sweep_done.
REQ-034 SHALL cover start while busy and cfg changes mid-sweep -> sweep unchanged from latched values; start+abort same cycle in IDLE -> stays IDLE.
REQ-035 SHALL cover resetn=0 asserted mid-sweep for one cycle -> all outputs zero after that edge, no sweep_done; new start afterwards runs normally.

Source files
------------

// File: rtl/sig_sweep_ctrl.sv
// Frequency sweep sequencer: steps a phase increment from f_start toward f_stop, holding each tone dwell+1 cycles.
// Outputs are registered and update on the edge after start is sampled. Abort and reset stop the sweep without a done pulse.
module sig_sweep_ctrl #(
  parameter int PHASE_W = 16,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] cfg_f_start,
  input  logic [PHASE_W-1:0] cfg_f_stop,
  input  logic [PHASE_W-1:0] cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               tone_en,
  output logic               busy,
  output logic               sweep_done
);

  typedef enum logic {S_IDLE = 1'b0, S_DWELL = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_f_start;
  logic [PHASE_W-1:0] r_f_stop;
  logic [PHASE_W-1:0] r_f_step;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_repeat;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_done;

  logic [PHASE_W:0]   w_sum;
  logic               w_adv;
  logic               w_tone_end;
  logic               w_finish;
  logic               w_launch;

  // One extra bit on the sum keeps a step past the top of the range from wrapping back to a low tone.
  assign w_sum      = {1'b0, r_phase} + {1'b0, r_f_step};
  assign w_adv      = (r_f_step != '0) && (w_sum <= {1'b0, r_f_stop});
  assign w_tone_end = (r_state == S_DWELL) && !abort && (r_cnt == '0);
  assign w_finish   = w_tone_end && !w_adv && !r_repeat;
  assign w_launch   = (r_state == S_IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !abort) w_state_nxt = S_DWELL;
      S_DWELL: if (abort || w_finish) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tone enable and busy are pure decodes of the state flop, so they toggle on the same edge as sweep_done.
  always_comb begin
    busy       = (r_state == S_DWELL);
    tone_en    = (r_state == S_DWELL);
    phase_inc  = r_phase;
    sweep_done = r_done;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_phase   <= '0;
      r_f_start <= '0;
      r_f_stop  <= '0;
      r_f_step  <= '0;
      r_dwell   <= '0;
      r_repeat  <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_launch) begin
        r_f_start <= cfg_f_start;
        r_f_stop  <= cfg_f_stop;
        r_f_step  <= cfg_f_step;
        r_dwell   <= cfg_dwell;
        r_repeat  <= cfg_repeat;
        r_phase   <= cfg_f_start;
        r_cnt     <= cfg_dwell;
      end else if (r_state == S_DWELL && !abort) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - DWELL_W'(1);
        end else if (w_adv) begin
          r_phase <= w_sum[PHASE_W-1:0];
          r_cnt   <= r_dwell;
        end else if (r_repeat) begin
          r_phase <= r_f_start;
          r_cnt   <= r_dwell;
        end
      end
    end
  end

endmodule

// File: tb/tb_sig_sweep_ctrl.sv
// Directed bench for sig_sweep_ctrl: table of sweep configurations plus hand sequences for repeat, abort and reset.
module tb_sig_sweep_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [15:0] cfg_f_start;
  logic [15:0] cfg_f_stop;
  logic [15:0] cfg_f_step;
  logic [15:0] cfg_dwell;
  logic        cfg_repeat;
  logic [15:0] phase_inc;
  logic        tone_en;
  logic        busy;
  logic        sweep_done;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] f_start;
    logic [15:0] f_stop;
    logic [15:0] f_step;
    logic [15:0] dwell;
    int          n_tones;
    logic [15:0] exp_step;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs [6];

  sig_sweep_ctrl #(.PHASE_W(16), .DWELL_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .cfg_f_start(cfg_f_start),
    .cfg_f_stop (cfg_f_stop),
    .cfg_f_step (cfg_f_step),
    .cfg_dwell  (cfg_dwell),
    .cfg_repeat (cfg_repeat),
    .phase_inc  (phase_inc),
    .tone_en    (tone_en),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  wire [18:0] w_outs = {phase_inc, tone_en, busy, sweep_done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input vec_t v, input logic rep);
    cfg_f_start = v.f_start;
    cfg_f_stop  = v.f_stop;
    cfg_f_step  = v.f_step;
    cfg_dwell   = v.dwell;
    cfg_repeat  = rep;
    start       = 1'b1;
    abort       = 1'b0;
    tick();
    start       = 1'b0;
  endtask

  // Checks ncyc busy cycles; cfg inputs are scrambled and start is pulsed to prove the shadow copy is used.
  task automatic body(input vec_t v, input int ncyc, input string name);
    logic [15:0] ep;
    for (int k = 0; k < ncyc; k++) begin
      ep = 16'(int'(v.f_start) + ((k / (int'(v.dwell) + 1)) % v.n_tones) * int'(v.exp_step));
      chk(name, w_outs, {ep, 1'b1, 1'b1, 1'b0});
      cfg_f_start = 16'($urandom);
      cfg_f_stop  = 16'($urandom);
      cfg_f_step  = 16'($urandom);
      cfg_dwell   = 16'($urandom_range(0, 7));
      cfg_repeat  = 1'($urandom_range(0, 1));
      start       = ((k % 2) == 1) && (k < ncyc - 1);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h1000, 16'h1300, 16'h0100, 16'd3, 4, 16'h0100, 16'h1300};
    vecs[1] = '{16'hFF00, 16'hFFFF, 16'h0080, 16'd0, 2, 16'h0080, 16'hFF80};
    vecs[2] = '{16'h2000, 16'h3000, 16'h0000, 16'd5, 1, 16'h0000, 16'h2000};
    vecs[3] = '{16'h2000, 16'h1000, 16'h0100, 16'd5, 1, 16'h0000, 16'h2000};
    vecs[4] = '{16'h0010, 16'h0035, 16'h0010, 16'd1, 3, 16'h0010, 16'h0030};
    vecs[5] = '{16'h0000, 16'hFFFF, 16'h8000, 16'd2, 2, 16'h8000, 16'h8000};

    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_f_start = 16'h1234; cfg_f_stop = 16'hFFFF; cfg_f_step = 16'h1; cfg_dwell = 16'd2; cfg_repeat = 1'b1;
    tick();
    tick();
    chk("reset_state", w_outs, 19'h0);
    resetn = 1'b1;
    tick();
    chk("idle_after_reset", w_outs, 19'h0);

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i], 1'b0);
      body(vecs[i], vecs[i].n_tones * (int'(vecs[i].dwell) + 1), $sformatf("sweep%0d", i));
      chk($sformatf("done_pulse%0d", i), w_outs, {vecs[i].exp_last, 1'b0, 1'b0, 1'b1});
      tick();
      chk($sformatf("done_clear%0d", i), w_outs, {vecs[i].exp_last, 1'b0, 1'b0, 1'b0});
    end

    // Repeat: wraps from 0x1300 back to 0x1000 with no done pulse, then abort mid-tone.
    launch(vecs[0], 1'b1);
    body(vecs[0], 22, "repeat");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("repeat_abort", {16'h0, w_outs[2:0]}, 19'h0);
    tick();
    chk("repeat_abort_nodone", {16'h0, w_outs[2:0]}, 19'h0);

    // start and abort together in IDLE must not launch.
    cfg_f_start = 16'h4000; cfg_f_stop = 16'h5000; cfg_f_step = 16'h10; cfg_dwell = 16'd1; cfg_repeat = 1'b0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {16'h0, w_outs[2:0]}, 19'h0);
    tick();
    chk("start_abort_idle2", {16'h0, w_outs[2:0]}, 19'h0);

    // Abort on the completing cycle wins over the done pulse.
    launch(vecs[2], 1'b0);
    body(vecs[2], 5, "abort_late");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_at_finish", {16'h0, w_outs[2:0]}, 19'h0);
    tick();
    chk("abort_at_finish2", {16'h0, w_outs[2:0]}, 19'h0);

    // Reset mid-sweep clears everything, then a fresh sweep runs normally.
    launch(vecs[0], 1'b0);
    body(vecs[0], 5, "pre_reset");
    resetn = 1'b0;
    tick();
    chk("mid_reset", w_outs, 19'h0);
    resetn = 1'b1;
    tick();
    chk("post_reset_nodone", w_outs, 19'h0);
    launch(vecs[1], 1'b0);
    body(vecs[1], 2, "after_reset");
    chk("after_reset_done", w_outs, {16'hFF80, 1'b0, 1'b0, 1'b1});
    tick();
    chk("after_reset_clear", w_outs, {16'hFF80, 1'b0, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
